// File: rtl/ccc_csr_writeback.sv
// CCC configuration write-back: validates decoded CCC updates, strobes the CSR
// hardware-input fields once, then waits for the readback to confirm the change.
module ccc_csr_writeback #(
    parameter int          CONFIRM_TIMEOUT = 8,
    parameter logic [15:0] MIN_MXL         = 16'd8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_type_i,
    input  logic        req_virtual_i,
    input  logic [15:0] req_data_i,
    input  logic [6:0]  sta_addr_i,
    input  logic [6:0]  virt_sta_addr_i,
    input  logic        sta_addr_valid_i,
    input  logic        virt_sta_addr_valid_i,
    input  logic [6:0]  dyn_addr_i,
    input  logic [6:0]  virt_dyn_addr_i,
    input  logic        dyn_addr_valid_i,
    input  logic        virt_dyn_addr_valid_i,
    input  logic [15:0] mwl_i,
    input  logic [15:0] mrl_i,
    output logic        dyn_we_o,
    output logic        virt_dyn_we_o,
    output logic [6:0]  dyn_addr_o,
    output logic [6:0]  virt_dyn_addr_o,
    output logic        dyn_valid_o,
    output logic        virt_dyn_valid_o,
    output logic        set_mwl_o,
    output logic        set_mrl_o,
    output logic [15:0] mxl_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    localparam logic [2:0] T_SETDASA  = 3'd0;
    localparam logic [2:0] T_SETAASA  = 3'd1;
    localparam logic [2:0] T_SETNEWDA = 3'd2;
    localparam logic [2:0] T_RSTDAA   = 3'd3;
    localparam logic [2:0] T_ENTDAA   = 3'd4;
    localparam logic [2:0] T_SETMWL   = 3'd5;
    localparam logic [2:0] T_SETMRL   = 3'd6;
    localparam logic [2:0] T_ILLEGAL  = 3'd7;

    localparam int              CNT_W   = $clog2(CONFIRM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CONFIRM_TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WRITE, S_CONFIRM, S_FINISH} state_t;

    state_t            r_state;
    logic [2:0]        r_type;
    logic              r_virt;
    logic [15:0]       r_data;
    logic [6:0]        r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_code;
    logic              r_dyn_we, r_virt_dyn_we, r_dyn_valid, r_virt_dyn_valid;
    logic [6:0]        r_dyn_addr, r_virt_dyn_addr;
    logic              r_set_mwl, r_set_mrl;
    logic [15:0]       r_mxl;

    logic              w_is_addr, w_is_mxl;
    logic [6:0]        w_sel_dyn_addr, w_sel_sta_addr, w_new_addr;
    logic              w_sel_dyn_valid, w_sel_sta_valid, w_bad_addr;
    logic [1:0]        w_code;
    logic              w_match, w_reject, w_timeout;

    // Virtual selection only matters for address types; RSTDAA/MWL/MRL ignore it.
    always_comb begin
        w_is_addr = (r_type == T_SETDASA) || (r_type == T_SETAASA) ||
                    (r_type == T_SETNEWDA) || (r_type == T_ENTDAA);
        w_is_mxl  = (r_type == T_SETMWL) || (r_type == T_SETMRL);
        w_sel_dyn_addr  = r_virt ? virt_dyn_addr_i       : dyn_addr_i;
        w_sel_dyn_valid = r_virt ? virt_dyn_addr_valid_i : dyn_addr_valid_i;
        w_sel_sta_addr  = r_virt ? virt_sta_addr_i       : sta_addr_i;
        w_sel_sta_valid = r_virt ? virt_sta_addr_valid_i : sta_addr_valid_i;
        w_new_addr = (r_type == T_SETAASA) ? w_sel_sta_addr : r_data[7:1];
        w_bad_addr = (w_new_addr == 7'h00) || (w_new_addr == 7'h02) ||
                     (w_new_addr == 7'h7E) || (w_new_addr == 7'h7F);

        w_code = 2'd0;
        if (r_type == T_ILLEGAL)
            w_code = 2'd2;
        else if (w_is_addr && w_bad_addr)
            w_code = 2'd1;
        else if (((r_type == T_SETDASA) || (r_type == T_ENTDAA)) && w_sel_dyn_valid)
            w_code = 2'd2;
        else if ((r_type == T_SETAASA) && !w_sel_sta_valid)
            w_code = 2'd2;
        else if ((r_type == T_SETNEWDA) && !w_sel_dyn_valid)
            w_code = 2'd2;
        else if (w_is_mxl && (r_data < MIN_MXL))
            w_code = 2'd1;

        w_match = 1'b0;
        if (w_is_addr)
            w_match = (w_sel_dyn_addr == r_addr) && w_sel_dyn_valid;
        else if (r_type == T_RSTDAA)
            w_match = !dyn_addr_valid_i && !virt_dyn_addr_valid_i;
        else if (r_type == T_SETMWL)
            w_match = (mwl_i == r_data);
        else if (r_type == T_SETMRL)
            w_match = (mrl_i == r_data);
    end

    assign w_reject  = (r_state == S_CHECK) && (w_code != 2'd0);
    assign w_timeout = (r_state == S_CONFIRM) && !w_match && (r_cnt == CNT_MAX);

    assign req_ready_o      = (r_state == S_IDLE);
    assign done_o           = (r_state == S_CONFIRM) && w_match;
    assign err_o            = w_reject || w_timeout;
    assign err_code_o       = w_reject ? w_code : (w_timeout ? 2'd3 : r_code);
    assign dyn_we_o         = r_dyn_we;
    assign virt_dyn_we_o    = r_virt_dyn_we;
    assign dyn_addr_o       = r_dyn_addr;
    assign virt_dyn_addr_o  = r_virt_dyn_addr;
    assign dyn_valid_o      = r_dyn_valid;
    assign virt_dyn_valid_o = r_virt_dyn_valid;
    assign set_mwl_o        = r_set_mwl;
    assign set_mrl_o        = r_set_mrl;
    assign mxl_o            = r_mxl;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state          <= S_IDLE;
            r_type           <= 3'd0;
            r_virt           <= 1'b0;
            r_data           <= 16'd0;
            r_addr           <= 7'd0;
            r_cnt            <= '0;
            r_code           <= 2'd0;
            r_dyn_we         <= 1'b0;
            r_virt_dyn_we    <= 1'b0;
            r_dyn_addr       <= 7'd0;
            r_virt_dyn_addr  <= 7'd0;
            r_dyn_valid      <= 1'b0;
            r_virt_dyn_valid <= 1'b0;
            r_set_mwl        <= 1'b0;
            r_set_mrl        <= 1'b0;
            r_mxl            <= 16'd0;
        end else begin
            // Strobe outputs are only non-zero for the single WRITE cycle.
            r_dyn_we         <= 1'b0;
            r_virt_dyn_we    <= 1'b0;
            r_dyn_addr       <= 7'd0;
            r_virt_dyn_addr  <= 7'd0;
            r_dyn_valid      <= 1'b0;
            r_virt_dyn_valid <= 1'b0;
            r_set_mwl        <= 1'b0;
            r_set_mrl        <= 1'b0;
            r_mxl            <= 16'd0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_type  <= req_type_i;
                        r_virt  <= req_virtual_i;
                        r_data  <= req_data_i;
                        r_code  <= 2'd0;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_code != 2'd0) begin
                        r_code  <= w_code;
                        r_state <= S_FINISH;
                    end else begin
                        r_addr  <= w_new_addr;
                        r_cnt   <= '0;
                        r_state <= S_WRITE;
                        if (w_is_addr && r_virt) begin
                            r_virt_dyn_we    <= 1'b1;
                            r_virt_dyn_addr  <= w_new_addr;
                            r_virt_dyn_valid <= 1'b1;
                        end else if (w_is_addr) begin
                            r_dyn_we    <= 1'b1;
                            r_dyn_addr  <= w_new_addr;
                            r_dyn_valid <= 1'b1;
                        end else if (r_type == T_RSTDAA) begin
                            r_dyn_we      <= 1'b1;
                            r_virt_dyn_we <= 1'b1;
                        end else if (r_type == T_SETMWL) begin
                            r_set_mwl <= 1'b1;
                            r_mxl     <= r_data;
                        end else begin
                            r_set_mrl <= 1'b1;
                            r_mxl     <= r_data;
                        end
                    end
                end
                S_WRITE: r_state <= S_CONFIRM;
                S_CONFIRM: begin
                    if (w_match) begin
                        r_state <= S_FINISH;
                    end else if (r_cnt == CNT_MAX) begin
                        r_code  <= 2'd3;
                        r_state <= S_FINISH;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

endmodule
